// File: rtl/encoder_pkg.sv
// encoder_pkg: shared sizing helpers for the priority encoder tree
package encoder_pkg;

    // Index width for a given number of wires; a single wire still gets a 1-bit index.
    function automatic int idx_width(input int num_wire);
        return (num_wire <= 1) ? 1 : $clog2(num_wire);
    endfunction

    // Number of tree leaves after zero-padding up to a power of two.
    function automatic int leaf_count(input int num_wire);
        return 1 << idx_width(num_wire);
    endfunction

endpackage

// File: rtl/encoder_node.sv
// encoder_node: merges two child (valid, index) results, upper child wins when valid
module encoder_node
    import encoder_pkg::*;
#(
    parameter int IW  = 1,
    parameter int LVL = 0
) (
    input  logic          lo_valid_i,
    input  logic [IW-1:0] lo_index_i,
    input  logic          hi_valid_i,
    input  logic [IW-1:0] hi_index_i,
    output logic          valid_o,
    output logic [IW-1:0] index_o
);

    // Child indices only occupy bits below LVL, so the select bit is ORed in at LVL.
    always_comb begin
        valid_o = lo_valid_i | hi_valid_i;
        index_o = (hi_valid_i ? hi_index_i : lo_index_i) | (IW'(hi_valid_i) << LVL);
    end

endmodule

// File: rtl/priority_encoder.sv
// priority_encoder: index of the highest asserted wire via a log2-depth reduction tree
module priority_encoder
    import encoder_pkg::*;
#(
    parameter int NUM_WIRE = 16,
    parameter int REG_OUT  = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_WIRE-1:0]                  wire_in,
    output logic [idx_width(NUM_WIRE)-1:0]       index_o,
    output logic                                 index_valid_o
);

    localparam int IDX_W = idx_width(NUM_WIRE);
    localparam int P     = leaf_count(NUM_WIRE);

    // Heap-ordered tree: node n has lower child 2n and upper child 2n+1, root is 1,
    // leaves P..2P-1 hold the zero-padded input wires.
    logic             node_v  [1:2*P-1];
    logic [IDX_W-1:0] node_ix [1:2*P-1];

    logic [IDX_W-1:0] index_d, index_q;
    logic             valid_d, valid_q;

    genvar d, i, k;

    for (k = 0; k < P; k++) begin : g_leaf
        if (k < NUM_WIRE) begin : g_real
            assign node_v[P+k] = wire_in[k];
        end else begin : g_pad
            assign node_v[P+k] = 1'b0;
        end
        assign node_ix[P+k] = '0;
    end

    for (d = 0; d < IDX_W; d++) begin : g_level
        for (i = 0; i < (1 << d); i++) begin : g_node
            encoder_node #(
                .IW  (IDX_W),
                .LVL (IDX_W - 1 - d)
            ) u_node (
                .lo_valid_i (node_v [2*((1<<d)+i)]),
                .lo_index_i (node_ix[2*((1<<d)+i)]),
                .hi_valid_i (node_v [2*((1<<d)+i)+1]),
                .hi_index_i (node_ix[2*((1<<d)+i)+1]),
                .valid_o    (node_v [(1<<d)+i]),
                .index_o    (node_ix[(1<<d)+i])
            );
        end
    end

    assign index_d = node_ix[1];
    assign valid_d = node_v[1];

    // Optional output stage; reset wins over capture so reset-cycle inputs are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            index_q <= '0;
            valid_q <= 1'b0;
        end else begin
            index_q <= index_d;
            valid_q <= valid_d;
        end
    end

    assign index_o       = (REG_OUT != 0) ? index_q : index_d;
    assign index_valid_o = (REG_OUT != 0) ? valid_q : valid_d;

endmodule

// File: tb/tb_priority_encoder.sv
// tb_priority_encoder: randomized and directed checks of the encoder against a highest-bit model
module tb_priority_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] w16c = '0;
    logic [15:0] w16r = '0;
    logic [4:0]  w5 = '0;
    logic [0:0]  w1 = '0;

    logic [3:0] ix16c, ix16r;
    logic [2:0] ix5;
    logic [0:0] ix1;
    logic       v16c, v16r, v5, v1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    priority_encoder #(.NUM_WIRE(16), .REG_OUT(0)) u_c16 (
        .clk_i(clk), .rst_i(rst), .wire_in(w16c), .index_o(ix16c), .index_valid_o(v16c));
    priority_encoder #(.NUM_WIRE(16), .REG_OUT(1)) u_r16 (
        .clk_i(clk), .rst_i(rst), .wire_in(w16r), .index_o(ix16r), .index_valid_o(v16r));
    priority_encoder #(.NUM_WIRE(5), .REG_OUT(0)) u_c5 (
        .clk_i(clk), .rst_i(rst), .wire_in(w5), .index_o(ix5), .index_valid_o(v5));
    priority_encoder #(.NUM_WIRE(1), .REG_OUT(0)) u_c1 (
        .clk_i(clk), .rst_i(rst), .wire_in(w1), .index_o(ix1), .index_valid_o(v1));

    // Reference: scan downward for the highest set bit; all-zero gives index 0.
    function automatic int ref_idx(input logic [31:0] v, input int n);
        for (int b = n - 1; b >= 0; b--) if (v[b]) return b;
        return 0;
    endfunction

    function automatic logic [31:0] ref_val(input logic [31:0] v, input int n);
        return (n >= 32) ? {31'b0, |v} : {31'b0, (v & ((32'd1 << n) - 1)) != 0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_c16(input string tag);
        chk({tag, "_idx"}, {28'b0, ix16c}, ref_idx({16'b0, w16c}, 16));
        chk({tag, "_vld"}, {31'b0, v16c}, ref_val({16'b0, w16c}, 16));
    endtask

    function automatic logic [15:0] rnd16(input int mode);
        return mode ? 16'($urandom) : 16'($urandom_range(0, 1) << $urandom_range(0, 15));
    endfunction

    logic [15:0] pend;

    initial begin
        // reset phase: registered outputs held at 0 while input is 8000
        rst = 1'b1;
        w16r = 16'h8000;
        w16c = 16'h0000;
        @(posedge clk); #1;
        chk("rst1_idx", {28'b0, ix16r}, 0);
        chk("rst1_vld", {31'b0, v16r}, 0);
        chk_c16("zero_in_reset");
        w16c = 16'h0421;
        @(posedge clk); #1;
        chk("rst2_idx", {28'b0, ix16r}, 0);
        chk("rst2_vld", {31'b0, v16r}, 0);
        chk_c16("comb_ignores_rst");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_idx", {28'b0, ix16r}, 15);
        chk("rel_vld", {31'b0, v16r}, 1);
        w16r = 16'h0008;
        #1;
        chk("hold_idx", {28'b0, ix16r}, 15);
        @(posedge clk); #1;
        chk("lat_idx", {28'b0, ix16r}, 3);
        chk("lat_vld", {31'b0, v16r}, 1);

        // one-hot sweep and directed multi-hot patterns
        for (int k = 0; k < 16; k++) begin
            w16c = 16'(1 << k);
            #1;
            chk("onehot_idx", {28'b0, ix16c}, k);
            chk("onehot_vld", {31'b0, v16c}, 1);
        end
        w16c = 16'h0000; #1;
        chk("zero_idx", {28'b0, ix16c}, 0);
        chk("zero_vld", {31'b0, v16c}, 0);
        w16c = 16'h0421; #1; chk("m0421", {28'b0, ix16c}, 10);
        w16c = 16'hFFFF; #1; chk("mFFFF", {28'b0, ix16c}, 15);
        w16c = 16'h0003; #1; chk("m0003", {28'b0, ix16c}, 1);
        chk("m0003_vld", {31'b0, v16c}, 1);

        // odd width and single wire
        w5 = 5'b10000; #1; chk("w5_10000", {29'b0, ix5}, 4);
        w5 = 5'b00110; #1; chk("w5_00110", {29'b0, ix5}, 2);
        chk("w5_00110_vld", {31'b0, v5}, 1);
        w5 = 5'b00000; #1;
        chk("w5_zero_idx", {29'b0, ix5}, 0);
        chk("w5_zero_vld", {31'b0, v5}, 0);
        w1 = 1'b1; #1;
        chk("w1_one_idx", {31'b0, ix1}, 0);
        chk("w1_one_vld", {31'b0, v1}, 1);
        w1 = 1'b0; #1;
        chk("w1_zero_vld", {31'b0, v1}, 0);

        // random stress, registered path checked one cycle after each capture
        @(negedge clk);
        pend = rnd16(1);
        w16r = pend;
        for (int n = 0; n < 4000; n++) begin
            w16c = rnd16(n & 1);
            w5 = 5'($urandom);
            w1 = 1'($urandom);
            #1;
            chk_c16("rnd_c16");
            chk("rnd_c5_idx", {29'b0, ix5}, ref_idx({27'b0, w5}, 5));
            chk("rnd_c5_vld", {31'b0, v5}, ref_val({27'b0, w5}, 5));
            chk("rnd_c1_vld", {31'b0, v1}, {31'b0, w1});
            chk("rnd_c1_idx", {31'b0, ix1}, 0);
            @(posedge clk); #1;
            chk("rnd_r16_idx", {28'b0, ix16r}, ref_idx({16'b0, pend}, 16));
            chk("rnd_r16_vld", {31'b0, v16r}, ref_val({16'b0, pend}, 16));
            pend = rnd16((n >> 1) & 1);
            w16r = pend;
        end

        // mid-run reset discards a live input
        w16r = 16'h0100;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_idx", {28'b0, ix16r}, 0);
        chk("rst_mid_vld", {31'b0, v16r}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_mid_idx", {28'b0, ix16r}, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
